// File: rtl/serial_shifter.sv
// serial_shifter
// Multi-cycle shifter with the same operation encoding and results as the
// single-cycle combinational shifter. A request is taken over a valid/ready
// handshake. The operand is shifted one bit per clock, or four bits per clock
// while the remaining count is at least 4 in the fast-step build. The result
// is returned over a second valid/ready handshake.
//
// Optional feature macro: SERIAL_SHIFTER_FAST_STEP_EN
//   Defined   : step by 4 while cnt >= 4, then by 1.
//   Undefined : step by 1 only.
//   Results are identical in both builds; only the latency differs.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  block can accept a request (IDLE)
//   B          in   operand [size-1:0]
//   shamnt     in   shift amount [$clog2(size)-1:0]
//   S          in   S[1]=1 arithmetic / 0 logical, S[0]=1 left / 0 right
//   out_valid  out  H holds a valid result (DONE)
//   out_ready  in   consumer accepts the result
//   H          out  result (the data register, driven continuously)
//   busy       out  request in flight (SHIFT or DONE), equals ~in_ready
module serial_shifter #(
  parameter int size = 32,
  localparam int W = $clog2(size)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] B,
  input  logic [W-1:0]    shamnt,
  input  logic [1:0]      S,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] H,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [size-1:0] data_reg, data_next;
  logic [W-1:0]    cnt_reg, cnt_next;
  logic [1:0]      mode_reg, mode_next;
  logic            fill;

  // Arithmetic right shifts replicate the sign bit. The data register MSB
  // holds the latched B[size-1] for the whole operation, because an
  // arithmetic right shift never changes it. Left shifts always fill with 0.
  assign fill = mode_reg[1] & ~mode_reg[0] & data_reg[size-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = B;
          cnt_next   = shamnt;
          mode_next  = S;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // The cnt==0 check costs one cycle, so shamnt=0 still spends one
        // cycle in SHIFT before the result is presented.
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
`ifdef SERIAL_SHIFTER_FAST_STEP_EN
          if (cnt_reg >= W'(4)) begin
            if (mode_reg[0]) data_next = {data_reg[size-5:0], 4'b0000};
            else             data_next = {{4{fill}}, data_reg[size-1:4]};
            cnt_next = cnt_reg - W'(4);
          end else begin
            if (mode_reg[0]) data_next = {data_reg[size-2:0], 1'b0};
            else             data_next = {fill, data_reg[size-1:1]};
            cnt_next = cnt_reg - W'(1);
          end
`else
          if (mode_reg[0]) data_next = {data_reg[size-2:0], 1'b0};
          else             data_next = {fill, data_reg[size-1:1]};
          cnt_next = cnt_reg - W'(1);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = ~in_ready;
  assign H         = data_reg;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter (size = 32).
// Latency is counted with the accept edge as edge 1. For shamnt=0, out_valid
// is therefore first seen after edge 2.
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] B;
  logic [4:0]  shamnt;
  logic [1:0]  S;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] H;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_shifter #(.size(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .B(B), .shamnt(shamnt), .S(S), .out_valid(out_valid),
    .out_ready(out_ready), .H(H), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] b;
    logic [4:0]  sh;
    logic [1:0]  s;
    int          stall;
    logic [31:0] exp_h;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] sh);
`ifdef SERIAL_SHIFTER_FAST_STEP_EN
    return int'(sh) / 4 + int'(sh) % 4 + 2;
`else
    return int'(sh) + 2;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [31:0] b, input logic [4:0] sh, input logic [1:0] s);
    if (s[0])      return b << sh;
    else if (s[1]) return $unsigned($signed(b) >>> sh);
    else           return b >> sh;
  endfunction

  // Runs one operation: accept, wait for out_valid (bounded), hold
  // out_ready low for 'stall' cycles, then complete the handshake.
  // With 'pulse' set, in_valid is toggled with another operand while the
  // request is in flight; those pulses must be ignored.
  task automatic run_op(input string name, input logic [31:0] b, input logic [4:0] sh,
                        input logic [1:0] s, input int stall, input bit pulse,
                        input logic [31:0] exp_h, input bit verbose);
    int lat;
    @(negedge clk);
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    B = b; shamnt = sh; S = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, ".busy"}, {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 80) begin
      if (pulse) begin in_valid = ~in_valid; B = 32'h1234_5678; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, ".lat"}, lat, exp_lat(sh));
    chk({name, ".H"}, H, exp_h);
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin in_valid = ~in_valid; B = 32'h1234_5678; end
      @(posedge clk);
      @(negedge clk);
      chk({name, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, ".hold_H"}, H, exp_h);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".ret_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    chk({name, ".busy_eq"}, {31'd0, busy}, {31'd0, ~in_ready});
    if (verbose)
      $display("op %s B=%h sh=%0d S=%b H=%h lat=%0d", name, b, sh, s, H, lat);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] rb, eh;
    logic [4:0]  rsh;
    logic [1:0]  rs;

    vecs[0] = '{32'h8000_0000, 5'd4,  2'b00, 0, 32'h0800_0000};
    vecs[1] = '{32'hF000_0000, 5'd8,  2'b10, 1, 32'hFFF0_0000};
    vecs[2] = '{32'h7000_0000, 5'd8,  2'b10, 0, 32'h0070_0000};
    vecs[3] = '{32'h0000_0001, 5'd31, 2'b01, 0, 32'h8000_0000};
    vecs[4] = '{32'h0000_0001, 5'd31, 2'b11, 2, 32'h8000_0000};
    vecs[5] = '{32'h8000_0001, 5'd31, 2'b10, 0, 32'hFFFF_FFFF};
    vecs[6] = '{32'hA5A5_A5A5, 5'd5,  2'b00, 0, 32'h052D_2D2D};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; B = '0; shamnt = '0; S = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.H", H, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].sh, vecs[i].s,
             vecs[i].stall, 1'b0, vecs[i].exp_h, 1'b1);

    // Zero shift with 5 cycles of backpressure and ignored in_valid pulses.
    run_op("zero_bp", 32'hDEAD_BEEF, 5'd0, 2'b00, 5, 1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("zero_bp.not_queued", {31'd0, busy}, 32'd0);

    // Reset three cycles into a shamnt=20 operation.
    @(negedge clk);
    B = 32'hFFFF_0000; shamnt = 5'd20; S = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid.H", H, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rst_mid.no_result", seen, 0);
    end
    $display("op rst_mid aborted, in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_op("after_rst", 32'h0000_00FF, 5'd4, 2'b01, 0, 1'b0, 32'h0000_0FF0, 1'b1);

    // Randomised sweep: every shamnt with every S, plus random operands.
    for (int i = 0; i < 1000; i++) begin
      rb  = $urandom;
      rsh = (i < 128) ? 5'(i % 32) : 5'($urandom_range(0, 31));
      rs  = (i < 128) ? 2'(i / 32) : 2'($urandom_range(0, 3));
      eh  = model(rb, rsh, rs);
      run_op($sformatf("rnd%0d", i), rb, rsh, rs, int'($urandom_range(0, 3)),
             1'b0, eh, 1'b0);
    end
    $display("op random sweep of 1000 operations complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle, area-reduced counterpart of the core's single-cycle combinational shifter. It accepts a shift request over a valid/ready handshake, shifts the operand one bit per clock (or four with the fast-step option), and returns the result over a second valid/ready handshake. It is intended for RV32I builds where the barrel shifter's area is not affordable; the execute stage stalls on `in_ready`/`out_valid`. Operation encoding and results are bit-identical to the combinational shifter.

## Interface
- `size`, 32, operand width; must be a power of two, ≥ 8.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `B` input `size`: operand.
- `shamnt` input `$clog2(size)`: shift amount.
- `S` input 2: `S[1]`=1 arithmetic, 0 logical; `S[0]`=0 right, 1 left.
- `out_valid` output 1: `H` holds a valid result.
- `out_ready` input 1: consumer accepts the result.
- `H` output `size`: result.
- `busy` output 1: a request is in flight (SHIFT or DONE state).

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch `B` into the data register, `shamnt` into the counter `cnt`, and `S` into the mode register, then go to SHIFT.
  - SHIFT: if `cnt`==0, go to DONE. Otherwise shift the data register by one position and decrement `cnt`.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Fill rules:
  - Left shift (logical or arithmetic): shift in 0.
  - Logical right: shift in 0.
  - Arithmetic right: shift in the latched `B[size-1]`.
- `H` is the data register, driven continuously. It is defined only while `out_valid`=1 and is stable throughout DONE.
- Inputs are ignored outside IDLE. `in_valid` in SHIFT or DONE has no effect and the request is not queued.
- `shamnt`=0: the result equals `B` after one SHIFT cycle.
- Reset values: state=IDLE, data register=0, `cnt`=0, mode=0. Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `H`=0.
- Reset asserted mid-operation aborts the request immediately (asynchronously). No `out_valid` is produced for the aborted request.

## Timing
- Accept occurs on the edge where `in_valid` && `in_ready`.
- Default latency: `out_valid` rises on the (`shamnt`+2)-th rising edge after the accept edge.
  - Example: `shamnt`=0 → `out_valid` on the 2nd edge after accept.
  - Example: `shamnt`=31 → 33rd edge.
- `out_valid` holds until the edge where `out_ready`=1, then drops.
- `in_ready` returns to 1 in the cycle after that edge. There is no result-to-accept bypass, so back-to-back throughput is latency+1 cycles per operation.
- `out_ready` held high before DONE: the handshake completes on the first DONE cycle.
- `busy` equals NOT `in_ready`.

## Configuration
- `SERIAL_SHIFTER_FAST_STEP_EN`
  - Defined: in SHIFT, when `cnt` ≥ 4, shift by 4 positions with the same fill rule and subtract 4 from `cnt`; otherwise step by 1.
    - Latency = `shamnt`/4 + `shamnt`%4 + 2 edges (integer division).
    - Example: `shamnt`=31 → 7+3+2 = 12 edges.
  - Undefined: one bit per cycle only, with latency as given under Timing.
  - Results are identical in both builds.

## Test plan
- Logical right: `B`=0x8000_0000, `shamnt`=4, `S`=00 → `H`=0x0800_0000, `out_valid` on the 6th edge after accept (default build).
- Arithmetic right: `B`=0xF000_0000, `shamnt`=8, `S`=10 → `H`=0xFFF0_0000. Also `B`=0x7000_0000 with the same settings → `H`=0x0070_0000.
- Left edge cases:
  - `B`=0x0000_0001, `shamnt`=31, `S`=01 → `H`=0x8000_0000.
  - `S`=11 with the same operands → identical result.
  - Default build: 33 edges. `SERIAL_SHIFTER_FAST_STEP_EN` build: 12 edges.
- Zero shift and backpressure: `B`=0xDEAD_BEEF, `shamnt`=0, `out_ready` held low for 5 cycles → `out_valid` and `H`=0xDEAD_BEEF held stable. `in_valid` pulses with `B`=0x1234_5678 during this window are ignored. The first result is delivered, then the block returns to IDLE.
- Reset mid-shift: assert `rst` 3 cycles into a `shamnt`=20 operation → `in_ready`=1, `out_valid`=0, `H`=0 immediately. A new request afterwards (`B`=0x0000_00FF, `shamnt`=4, `S`=01) → `H`=0x0000_0FF0.
- Randomised sweep of 1000 operations, all `S` values, all `shamnt` values, random `out_ready` stalls → every `H` matches `>>`, `<<`, or signed `>>>`. Accept-to-`out_valid` latency matches the formula for the build under test.
